// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory write port
//
// Receives a word count N followed by 4*N little-endian bytes, packs each group
// of four bytes into a 32-bit word and writes the words to addresses 0..N-1.
// The core is held in reset while a session is in progress.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   start      single-cycle pulse; begins a load session from IDLE/DONE/ERR
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle
//   mem_we     single-cycle instruction memory write strobe
//   mem_addr   word address of the write
//   mem_wdata  word to write
//   busy       load session in progress
//   done       last session completed without error (sticky)
//   err        last session rejected (sticky)
//   core_rstn  active-low core reset; low while loading and after a rejected session
module imem_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int MEM_CAPACITY = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  core_rstn
);

    localparam logic [7:0] MAX_N = 8'(MEM_CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state, state_nx;
    logic [7:0]            n_len, n_len_nx;
    logic [ADDR_WIDTH-1:0] idx, idx_nx;
    logic [1:0]            bcnt, bcnt_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic [DATA_WIDTH-1:0] mem_wdata_nx;
    logic                  done_nx, err_nx;
    logic                  in_ready_nx, mem_we_nx, busy_nx, core_rstn_nx;
    logic                  take;

    // in_ready is itself a register, so the handshake term has no input-to-output path.
    assign take = in_valid && in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            n_len     <= '0;
            idx       <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            core_rstn <= 1'b1;
        end else begin
            state     <= state_nx;
            n_len     <= n_len_nx;
            idx       <= idx_nx;
            bcnt      <= bcnt_nx;
            shreg     <= shreg_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            done      <= done_nx;
            err       <= err_nx;
            in_ready  <= in_ready_nx;
            mem_we    <= mem_we_nx;
            busy      <= busy_nx;
            core_rstn <= core_rstn_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        n_len_nx     = n_len;
        idx_nx       = idx;
        bcnt_nx      = bcnt;
        shreg_nx     = shreg;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        done_nx      = done;
        err_nx       = err;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nx = S_LEN;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                    idx_nx   = '0;
                    bcnt_nx  = '0;
                end
            end
            S_LEN: begin
                if (take) begin
                    if (in_data == 8'd0 || in_data > MAX_N) begin
                        state_nx = S_ERR;
                        err_nx   = 1'b1;
                    end else begin
                        n_len_nx = in_data;
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    // Shift in from the top: after four bytes, byte 0 sits in bits [7:0].
                    shreg_nx = {in_data, shreg[DATA_WIDTH-1:8]};
                    bcnt_nx  = bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        state_nx     = S_WRITE;
                        mem_addr_nx  = idx;
                        mem_wdata_nx = {in_data, shreg[DATA_WIDTH-1:8]};
                    end
                end
            end
            S_WRITE: begin
                if (8'(idx) == n_len - 8'd1) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else begin
                    idx_nx   = idx + 1'b1;
                    state_nx = S_DATA;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Output registers are loaded from the next state so they line up with it.
        in_ready_nx  = (state_nx == S_LEN) || (state_nx == S_DATA);
        mem_we_nx    = (state_nx == S_WRITE);
        busy_nx      = (state_nx == S_LEN) || (state_nx == S_DATA) || (state_nx == S_WRITE);
        core_rstn_nx = !(busy_nx || (state_nx == S_ERR));
    end

endmodule
